// File: rtl/bus_pkg.sv
// Shared bus definitions: arbiter state encoding and master-count limit.
package bus_pkg;

  localparam int unsigned NUM_MASTERS_MAX = 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set bit of req at or after ptr, wrapping.
module rr_picker #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found_c,
  output logic [W-1:0] idx_c
);

  // Walk from farthest to nearest so the closest candidate to ptr wins.
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    for (int unsigned i = N; i > 0; i--) begin
      int unsigned c;
      c = (int'(ptr) + i - 1) % N;
      if (req[c]) begin
        found_c = 1'b1;
        idx_c   = W'(c);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin serial-bus arbiter with one parked split transaction.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned IDX_WIDTH   = 1,
  parameter bit          SPLIT_EN    = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] mreq,
  input  logic                   ssplit,
  input  logic                   split_done,
  output logic [NUM_MASTERS-1:0] mgrant,
  output logic [IDX_WIDTH-1:0]   gidx,
  output logic                   bus_busy,
  output logic [NUM_MASTERS-1:0] msplit
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > NUM_MASTERS_MAX ||
      IDX_WIDTH != $clog2(NUM_MASTERS)) begin : g_bad_params
    $error("bus_arbiter: illegal NUM_MASTERS/IDX_WIDTH combination");
  end

  arb_state_t             state, state_n;
  logic [NUM_MASTERS-1:0] mgrant_n, msplit_n;
  logic [IDX_WIDTH-1:0]   gidx_n, rr_ptr, rr_ptr_n, split_idx, split_idx_n;
  logic                   bus_busy_n;
  logic                   split_valid, split_valid_n;
  logic                   split_pend, split_pend_n;

  logic [NUM_MASTERS-1:0] elig_c;
  logic                   pick_found_c;
  logic [IDX_WIDTH-1:0]   pick_idx_c;
  logic                   abort_c;
  logic [IDX_WIDTH-1:0]   owner_next_c;

  assign elig_c  = mreq & ~msplit;
  assign abort_c = split_valid && ((mreq & msplit) == '0);
  assign owner_next_c = (32'(gidx) == NUM_MASTERS - 1) ? '0 : gidx + IDX_WIDTH'(1);

  rr_picker #(
    .N (NUM_MASTERS),
    .W (IDX_WIDTH)
  ) u_picker (
    .req     (elig_c),
    .ptr     (rr_ptr),
    .found_c (pick_found_c),
    .idx_c   (pick_idx_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB_IDLE;
      mgrant      <= '0;
      gidx        <= '0;
      bus_busy    <= 1'b0;
      msplit      <= '0;
      rr_ptr      <= '0;
      split_valid <= 1'b0;
      split_pend  <= 1'b0;
      split_idx   <= '0;
    end else begin
      state       <= state_n;
      mgrant      <= mgrant_n;
      gidx        <= gidx_n;
      bus_busy    <= bus_busy_n;
      msplit      <= msplit_n;
      rr_ptr      <= rr_ptr_n;
      split_valid <= split_valid_n;
      split_pend  <= split_pend_n;
      split_idx   <= split_idx_n;
    end
  end

  always_comb begin
    state_n       = state;
    mgrant_n      = mgrant;
    gidx_n        = gidx;
    bus_busy_n    = bus_busy;
    msplit_n      = msplit;
    rr_ptr_n      = rr_ptr;
    split_valid_n = split_valid;
    split_pend_n  = split_pend;
    split_idx_n   = split_idx;

    // Split bookkeeping that applies in any state.
    if (abort_c) begin
      split_valid_n = 1'b0;
      split_pend_n  = 1'b0;
      msplit_n      = '0;
    end else if (SPLIT_EN && split_valid && split_done) begin
      split_pend_n = 1'b1;
    end

    case (state)
      ARB_IDLE: begin
        if (split_valid && split_pend && !abort_c) begin
          state_n              = ARB_BUSY;
          mgrant_n             = '0;
          mgrant_n[split_idx]  = 1'b1;
          gidx_n               = split_idx;
          bus_busy_n           = 1'b1;
          split_valid_n        = 1'b0;
          split_pend_n         = 1'b0;
          msplit_n             = '0;
        end else if (pick_found_c) begin
          state_n              = ARB_BUSY;
          mgrant_n             = '0;
          mgrant_n[pick_idx_c] = 1'b1;
          gidx_n               = pick_idx_c;
          bus_busy_n           = 1'b1;
        end
      end
      ARB_BUSY: begin
        if (!mreq[gidx]) begin
          state_n    = ARB_IDLE;
          mgrant_n   = '0;
          bus_busy_n = 1'b0;
          rr_ptr_n   = owner_next_c;
        end else if (SPLIT_EN && ssplit && !split_valid) begin
          // Park the owner; a split_done in this same cycle is kept.
          state_n       = ARB_IDLE;
          mgrant_n      = '0;
          bus_busy_n    = 1'b0;
          rr_ptr_n      = owner_next_c;
          msplit_n      = mgrant;
          split_idx_n   = gidx;
          split_valid_n = 1'b1;
          split_pend_n  = split_done;
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed-vector testbench for bus_arbiter (split-enabled and split-disabled builds).
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst, rst2;
  logic [1:0] mreq, mreq2;
  logic       ssplit, split_done, ssplit2, split_done2;
  logic [1:0] mgrant, msplit, mgrant2, msplit2;
  logic       gidx, gidx2, bus_busy, bus_busy2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.NUM_MASTERS(2), .IDX_WIDTH(1), .SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .mreq(mreq), .ssplit(ssplit), .split_done(split_done),
    .mgrant(mgrant), .gidx(gidx), .bus_busy(bus_busy), .msplit(msplit)
  );

  bus_arbiter #(.NUM_MASTERS(2), .IDX_WIDTH(1), .SPLIT_EN(1'b0)) dut_ns (
    .clk(clk), .rst(rst2), .mreq(mreq2), .ssplit(ssplit2), .split_done(split_done2),
    .mgrant(mgrant2), .gidx(gidx2), .bus_busy(bus_busy2), .msplit(msplit2)
  );

  typedef struct packed {
    logic [1:0] mreq;
    logic       ssplit;
    logic       split_done;
    logic [1:0] grant;
    logic       gidx;
    logic       busy;
    logic [1:0] msplit;
  } vec_t;

  localparam int NV = 35;
  vec_t vecs [NV];

  function automatic vec_t mk(logic [1:0] r, logic s, logic d,
                              logic [1:0] g, logic gi, logic b, logic [1:0] ms);
    mk = '{mreq: r, ssplit: s, split_done: d, grant: g, gidx: gi, busy: b, msplit: ms};
  endfunction

  task automatic check(string name, logic [1:0] g, logic gi, logic b, logic [1:0] ms,
                       logic [1:0] eg, logic egi, logic eb, logic [1:0] ems);
    n_checks++;
    if (g !== eg || gi !== egi || b !== eb || ms !== ems) begin
      n_fail++;
      $display("FAIL %s: got mgrant=%b gidx=%b busy=%b msplit=%b, expected mgrant=%b gidx=%b busy=%b msplit=%b",
               name, g, gi, b, ms, eg, egi, eb, ems);
    end
  endtask

  initial begin
    //              mreq  ss sd  grant gi busy msplit
    vecs[0]  = mk(2'b01, 0, 0, 2'b01, 0, 1, 2'b00); // first grant, 1-cycle latency
    vecs[1]  = mk(2'b01, 0, 0, 2'b01, 0, 1, 2'b00);
    vecs[2]  = mk(2'b00, 0, 0, 2'b00, 0, 0, 2'b00); // release, rr_ptr -> 1
    vecs[3]  = mk(2'b11, 0, 0, 2'b10, 1, 1, 2'b00); // rr_ptr=1 picks M1
    vecs[4]  = mk(2'b11, 0, 0, 2'b10, 1, 1, 2'b00);
    vecs[5]  = mk(2'b11, 0, 0, 2'b10, 1, 1, 2'b00);
    vecs[6]  = mk(2'b01, 0, 0, 2'b00, 1, 0, 2'b00); // idle gap between owners
    vecs[7]  = mk(2'b11, 0, 0, 2'b01, 0, 1, 2'b00);
    vecs[8]  = mk(2'b11, 0, 0, 2'b01, 0, 1, 2'b00);
    vecs[9]  = mk(2'b11, 0, 0, 2'b01, 0, 1, 2'b00);
    vecs[10] = mk(2'b10, 0, 0, 2'b00, 0, 0, 2'b00);
    vecs[11] = mk(2'b11, 0, 0, 2'b10, 1, 1, 2'b00);
    vecs[12] = mk(2'b01, 0, 0, 2'b00, 1, 0, 2'b00);
    vecs[13] = mk(2'b01, 0, 0, 2'b01, 0, 1, 2'b00); // split scenario: M0 owns
    vecs[14] = mk(2'b01, 1, 0, 2'b00, 0, 0, 2'b01); // M0 parked
    vecs[15] = mk(2'b11, 0, 0, 2'b10, 1, 1, 2'b01); // M1 granted
    vecs[16] = mk(2'b11, 0, 1, 2'b10, 1, 1, 2'b01); // split_done latched, no preempt
    vecs[17] = mk(2'b11, 1, 0, 2'b10, 1, 1, 2'b01); // second ssplit ignored
    vecs[18] = mk(2'b01, 0, 0, 2'b00, 1, 0, 2'b01); // M1 releases
    vecs[19] = mk(2'b11, 0, 0, 2'b01, 0, 1, 2'b00); // parked M0 re-granted
    vecs[20] = mk(2'b01, 0, 0, 2'b01, 0, 1, 2'b00);
    vecs[21] = mk(2'b00, 0, 0, 2'b00, 0, 0, 2'b00);
    vecs[22] = mk(2'b10, 0, 0, 2'b10, 1, 1, 2'b00);
    vecs[23] = mk(2'b10, 1, 1, 2'b00, 1, 0, 2'b10); // split + done same cycle
    vecs[24] = mk(2'b10, 0, 0, 2'b10, 1, 1, 2'b00); // immediate re-grant
    vecs[25] = mk(2'b00, 0, 0, 2'b00, 1, 0, 2'b00);
    vecs[26] = mk(2'b01, 0, 0, 2'b01, 0, 1, 2'b00);
    vecs[27] = mk(2'b01, 1, 0, 2'b00, 0, 0, 2'b01);
    vecs[28] = mk(2'b10, 0, 0, 2'b10, 1, 1, 2'b00); // parked M0 aborts
    vecs[29] = mk(2'b10, 0, 0, 2'b10, 1, 1, 2'b00);
    vecs[30] = mk(2'b00, 1, 0, 2'b00, 1, 0, 2'b00); // release beats ssplit
    vecs[31] = mk(2'b00, 0, 1, 2'b00, 1, 0, 2'b00); // stray split_done ignored
    vecs[32] = mk(2'b10, 0, 0, 2'b10, 1, 1, 2'b00);
    vecs[33] = mk(2'b11, 1, 0, 2'b00, 1, 0, 2'b10); // M1 parked
    vecs[34] = mk(2'b11, 0, 0, 2'b01, 0, 1, 2'b10); // M0 busy, M1 parked

    rst = 1'b1; mreq = '0; ssplit = 1'b0; split_done = 1'b0;
    rst2 = 1'b1; mreq2 = '0; ssplit2 = 1'b0; split_done2 = 1'b0;
    @(posedge clk); #1;
    check("reset", mgrant, gidx, bus_busy, msplit, 2'b00, 1'b0, 1'b0, 2'b00);
    check("reset_ns", mgrant2, gidx2, bus_busy2, msplit2, 2'b00, 1'b0, 1'b0, 2'b00);
    rst = 1'b0; rst2 = 1'b0;

    for (int i = 0; i < NV; i++) begin
      mreq = vecs[i].mreq; ssplit = vecs[i].ssplit; split_done = vecs[i].split_done;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), mgrant, gidx, bus_busy, msplit,
            vecs[i].grant, vecs[i].gidx, vecs[i].busy, vecs[i].msplit);
    end

    // Asynchronous reset while busy with a parked master.
    mreq = 2'b00; ssplit = 1'b0; split_done = 1'b0;
    rst = 1'b1; #1;
    check("async_rst", mgrant, gidx, bus_busy, msplit, 2'b00, 1'b0, 1'b0, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    mreq = 2'b11;
    @(posedge clk); #1;
    check("post_rst_grant", mgrant, gidx, bus_busy, msplit, 2'b01, 1'b0, 1'b1, 2'b00);
    mreq = 2'b00;
    @(posedge clk); #1;

    // Split-disabled build: ssplit and split_done have no effect.
    mreq2 = 2'b01;
    @(posedge clk); #1;
    check("ns_grant", mgrant2, gidx2, bus_busy2, msplit2, 2'b01, 1'b0, 1'b1, 2'b00);
    ssplit2 = 1'b1; split_done2 = 1'b1;
    @(posedge clk); #1;
    check("ns_ssplit", mgrant2, gidx2, bus_busy2, msplit2, 2'b01, 1'b0, 1'b1, 2'b00);
    split_done2 = 1'b0;
    @(posedge clk); #1;
    check("ns_hold", mgrant2, gidx2, bus_busy2, msplit2, 2'b01, 1'b0, 1'b1, 2'b00);
    ssplit2 = 1'b0; mreq2 = 2'b00;
    @(posedge clk); #1;
    check("ns_release", mgrant2, gidx2, bus_busy2, msplit2, 2'b00, 1'b0, 1'b0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Arbitrates ownership of the serial system bus (swdata/srdata/smode/mvalid/svalid path) between NUM_MASTERS master ports.
- Round-robin grant, one owner at a time; the owner holds the bus until it drops its request.
- Supports one outstanding split transaction. When the addressed slave raises ssplit, the owner is parked and the bus is freed for others. The parked master is re-granted with priority once the slave signals split completion.
- Its grant and index outputs drive the master-side and slave-side bus muxes.

Parameters:
- NUM_MASTERS, 2, number of requesting master ports (2..8).
- IDX_WIDTH, 1, width of the owner index; must equal clog2(NUM_MASTERS).
- SPLIT_EN, 1, 1 = honour ssplit/split_done; 0 = both inputs ignored.

Ports:
- clk  in  1  bus clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mreq  in  NUM_MASTERS  per-master bus request; held high for the whole transaction, including while parked.
- ssplit  in  1  split request from the currently addressed slave (muxed bus signal).
- split_done  in  1  single-cycle pulse: the split slave is ready to resume.
- mgrant  out  NUM_MASTERS  one-hot grant, registered.
- gidx  out  IDX_WIDTH  index of the granted master; valid only while bus_busy=1.
- bus_busy  out  1  some master currently owns the bus.
- msplit  out  NUM_MASTERS  one-hot, marks the parked split master; all zero if none.

Behaviour:
- Reset values: mgrant=0, gidx=0, bus_busy=0, msplit=0, rr_ptr=0, split_valid=0, split_pend=0.
- FSM states:
  - IDLE: no owner.
  - BUSY: one owner.
- Eligible set: mreq with the parked master (msplit) masked out.
- IDLE selection, in priority order:
  - (a) split_valid && split_pend: grant the parked master; clear split_valid, split_pend and msplit.
  - (b) otherwise, the first eligible master at or after rr_ptr, wrapping modulo NUM_MASTERS.
  - (c) otherwise, stay in IDLE.
- Grant timing: mgrant, gidx and bus_busy update on the clock edge after the decision. Request-to-grant latency is 1 cycle from IDLE.
- BUSY, owner's mreq still high: hold the grant.
- BUSY, owner's mreq low:
  - next edge: mgrant=0, bus_busy=0, go to IDLE.
  - rr_ptr = owner+1, wrapping at NUM_MASTERS.
  - at least one IDLE cycle always separates two owners.
- BUSY, ssplit=1, SPLIT_EN=1 and split_valid=0:
  - next edge: record the owner in msplit and set split_valid.
  - drop the grant, go to IDLE; rr_ptr = owner+1.
- ssplit while split_valid=1: ignored; the owner keeps the bus. Only one split is supported.
- If the owner drops mreq and ssplit=1 in the same cycle, the release wins and no split is recorded.
- split_done handling:
  - sets split_pend when split_valid=1, in any state, including the same cycle as the split edge.
  - ignored when split_valid=0.
  - in BUSY it is only latched; the current owner is never pre-empted.
- Parked master drops mreq (abort): on the next edge clear split_valid, split_pend and msplit.
- mreq of a non-owner has no effect while BUSY.
- rst asserted mid-transaction: all state and outputs return to reset values immediately.
- Invariants: mgrant is one-hot or zero; mgrant & msplit == 0.

Decomposition:
- Shared package bus_pkg holds:
  - state encoding: ARB_IDLE=0, ARB_BUSY=1.
  - the NUM_MASTERS_MAX=8 constant.
- Sub-module rr_picker: combinational round-robin search over the eligible set from rr_ptr. It returns the found flag and the index, and is reusable for slave-select.
- bus_arbiter holds the FSM, rr_ptr and the split registers.

Test Plan:
- After rst, mreq=01 → mgrant=01 and gidx=0 one cycle later. Then mreq=00 → mgrant=00, and rr_ptr is 1.
- mreq=11 held, each owner releasing after 3 cycles → grants alternate 01,10,01. Exactly one idle cycle between owners.
- Split scenario:
  - M0 owns the bus; ssplit pulse → msplit=01, grant drops.
  - M1 (mreq=10) is granted; split_done pulses while M1 is busy, and M1 keeps the bus.
  - M1 releases → M0 is re-granted before any new M1 request, and msplit=00.
- SPLIT_EN=0: M0 owns the bus, ssplit=1 → grant unchanged, msplit=00.
- Second ssplit from M1 while M0 is parked → ignored; M1 keeps mgrant=10.
- Reset mid-transaction: rst asserted while BUSY with msplit=10 → all outputs read 0 in the same cycle, before any clock edge.
